// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (fetch F, data-load D)
// and the genrom read port.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (requesters plus ROM).
interface mem_port_arbiter_if #(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4
);
    localparam int DW = (2 ** MEM_EXTRA) * 8;

    // Fetch requester
    logic                 f_req;
    logic [MEM_ADDR:0]    f_addr;
    logic [MEM_EXTRA-1:0] f_extra;
    logic                 f_ack;
    logic [DW-1:0]        f_data;
    logic                 f_error;

    // Data-load requester
    logic                 d_req;
    logic [MEM_ADDR:0]    d_addr;
    logic [MEM_EXTRA-1:0] d_extra;
    logic                 d_ack;
    logic [DW-1:0]        d_data;
    logic                 d_error;

    // ROM read port
    logic [MEM_ADDR:0]    mem_addr;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [DW-1:0]        mem_data;
    logic                 mem_error;

    logic                 busy;

    modport slave (
        input  f_req, f_addr, f_extra,
        output f_ack, f_data, f_error,
        input  d_req, d_addr, d_extra,
        output d_ack, d_data, d_error,
        output mem_addr, mem_extra,
        input  mem_data, mem_error,
        output busy
    );

    modport master (
        output f_req, f_addr, f_extra,
        input  f_ack, f_data, f_error,
        output d_req, d_addr, d_extra,
        input  d_ack, d_data, d_error,
        input  mem_addr, mem_extra,
        output mem_data, mem_error,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one genrom read port between
// instruction fetch (F) and data load (D). One access takes four cycles:
// IDLE (grant) -> ISSUE (address at ROM) -> WAIT (capture) -> DONE (ack).
module mem_port_arbiter #(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int DW = (2 ** MEM_EXTRA) * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic {
        GRANT_F,
        GRANT_D
    } grant_t;

    state_t               state_q,     state_d;
    grant_t               sel_q,       sel_d;
    grant_t               last_q,      last_d;
    grant_t               win;
    logic [MEM_ADDR:0]    mem_addr_q,  mem_addr_d;
    logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
    logic [DW-1:0]        f_data_q,    f_data_d;
    logic                 f_error_q,   f_error_d;
    logic [DW-1:0]        d_data_q,    d_data_d;
    logic                 d_error_q,   d_error_d;

    // Next-state logic: arbitrate in IDLE, step through the access, capture in WAIT.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_extra_d = mem_extra_q;
        f_data_d    = f_data_q;
        f_error_d   = f_error_q;
        d_data_d    = d_data_q;
        d_error_d   = d_error_q;
        win         = GRANT_F;

        case (state_q)
            S_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    // On a tie the requester that did not win last time goes next.
                    if (bus.f_req && bus.d_req) begin
                        win = (last_q == GRANT_F) ? GRANT_D : GRANT_F;
                    end else begin
                        win = bus.f_req ? GRANT_F : GRANT_D;
                    end
                    sel_d       = win;
                    last_d      = win;
                    mem_addr_d  = (win == GRANT_F) ? bus.f_addr  : bus.d_addr;
                    mem_extra_d = (win == GRANT_F) ? bus.f_extra : bus.d_extra;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ROM output is valid now; only the selected requester's copy moves.
                if (sel_q == GRANT_F) begin
                    f_data_d  = bus.mem_data;
                    f_error_d = bus.mem_error;
                end else begin
                    d_data_d  = bus.mem_data;
                    d_error_d = bus.mem_error;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= GRANT_F;
            last_q      <= GRANT_D;
            mem_addr_q  <= '0;
            mem_extra_q <= '0;
            f_data_q    <= '0;
            f_error_q   <= 1'b0;
            d_data_q    <= '0;
            d_error_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_extra_q <= mem_extra_d;
            f_data_q    <= f_data_d;
            f_error_q   <= f_error_d;
            d_data_q    <= d_data_d;
            d_error_q   <= d_error_d;
        end
    end

    // Acks are decoded from DONE so they can never overlap and vanish on reset.
    assign bus.f_ack     = (state_q == S_DONE) && (sel_q == GRANT_F);
    assign bus.d_ack     = (state_q == S_DONE) && (sel_q == GRANT_D);
    assign bus.f_data    = f_data_q;
    assign bus.f_error   = f_error_q;
    assign bus.d_data    = d_data_q;
    assign bus.d_error   = d_error_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_extra = mem_extra_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
